// File: rtl/lifo_bitrev_ctrl.sv
// ============================================================================
// Module      : lifo_bitrev_ctrl
// Description : Word-to-serial initiator for a 1-bit push/pop stack. It pushes
//               a word LSB first, pops it back and returns the bit-reversed
//               word. The optional stall watchdog is enabled by defining
//               LIFO_CTRL_WDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lifo_bitrev_ctrl #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int STALL_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              stk_push,
    output logic              stk_pop,
    output logic              stk_din,
    input  logic              stk_dout,
    input  logic              stk_full,
    input  logic              stk_empty
`ifdef LIFO_CTRL_WDOG_EN
    ,
    output logic              err
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DATA_W - 1);

    generate
        if (DATA_W < 1 || DATA_W > DEPTH || STALL_MAX < 1) begin : g_param_check
            $error("lifo_bitrev_ctrl: DATA_W must be 1..DEPTH and STALL_MAX >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PUSH = 2'd1,
        S_POP  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_sreg;
    logic [DATA_W-1:0] r_obuf;

    logic w_push;
    logic w_pop;
    logic w_last;
    logic w_sel_bit;

    // Stack strobes depend only on the registered state and the stack flags,
    // so they can never both be high and drop as soon as reset hits the state.
    assign w_push = (r_state == S_PUSH) && !stk_full;
    assign w_pop  = (r_state == S_POP)  && !stk_empty;
    assign w_last = (r_cnt == c_LAST);

    always_comb begin
        w_sel_bit = 1'b0;
        for (int k = 0; k < DATA_W; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_sel_bit = r_sreg[k];
            end
        end
    end

    assign s_ready  = (r_state == S_IDLE);
    assign m_valid  = (r_state == S_OUT);
    assign m_data   = r_obuf;
    assign stk_push = w_push;
    assign stk_pop  = w_pop;
    assign stk_din  = (r_state == S_PUSH) && w_sel_bit;

`ifdef LIFO_CTRL_WDOG_EN
    localparam int SW = $clog2(STALL_MAX + 1);
    localparam logic [SW-1:0] c_STALL_LAST = SW'(STALL_MAX - 1);

    logic [SW-1:0] r_stall;
    logic          r_err;
    logic          w_stall;

    assign w_stall = ((r_state == S_PUSH) && stk_full) ||
                     ((r_state == S_POP)  && stk_empty);
    assign err     = r_err;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sreg  <= '0;
            r_obuf  <= '0;
`ifdef LIFO_CTRL_WDOG_EN
            r_stall <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (s_valid) begin
                        r_sreg  <= s_data;
                        r_cnt   <= '0;
                        r_state <= S_PUSH;
`ifdef LIFO_CTRL_WDOG_EN
                        r_err   <= 1'b0;
`endif
                    end
                end
                S_PUSH: begin
                    if (w_push) begin
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= S_POP;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_POP: begin
                    if (w_pop) begin
                        // Top-of-stack is combinational, so it is valid in the pop cycle.
                        for (int k = 0; k < DATA_W; k++) begin
                            if (r_cnt == CNT_W'(k)) begin
                                r_obuf[k] <= stk_dout;
                            end
                        end
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= S_OUT;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_OUT: begin
                    if (m_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

`ifdef LIFO_CTRL_WDOG_EN
            // A stall that lasts STALL_MAX cycles abandons the partial word.
            if (w_stall) begin
                if (r_stall == c_STALL_LAST) begin
                    r_stall <= '0;
                    r_err   <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end else begin
                    r_stall <= r_stall + SW'(1);
                end
            end else begin
                r_stall <= '0;
            end
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lifo_bitrev_ctrl.sv
// ============================================================================
// Module      : tb_lifo_bitrev_ctrl
// Description : Directed bench for lifo_bitrev_ctrl with a behavioural 1-bit
//               stack; watchdog sequence built only with LIFO_CTRL_WDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lifo_bitrev_ctrl;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;

    logic              clk;
    logic              rst_n;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              stk_push;
    logic              stk_pop;
    logic              stk_din;
    logic              stk_dout;
    logic              stk_full;
    logic              stk_empty;
`ifdef LIFO_CTRL_WDOG_EN
    logic              err;
`endif

    lifo_bitrev_ctrl #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .STALL_MAX (15)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .stk_push  (stk_push),
        .stk_pop   (stk_pop),
        .stk_din   (stk_din),
        .stk_dout  (stk_dout),
        .stk_full  (stk_full),
        .stk_empty (stk_empty)
`ifdef LIFO_CTRL_WDOG_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stack with combinational top-of-stack and force overrides.
    logic [DEPTH-1:0] stk_mem;
    int               stk_sp;
    logic             force_full;
    logic             force_empty;
    logic             stk_clr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stk_sp  <= 0;
            stk_mem <= '0;
        end else if (stk_clr) begin
            stk_sp <= 0;
        end else if (stk_push && stk_sp < DEPTH) begin
            stk_mem[stk_sp] <= stk_din;
            stk_sp          <= stk_sp + 1;
        end else if (stk_pop && stk_sp > 0) begin
            stk_sp <= stk_sp - 1;
        end
    end

    assign stk_dout  = (stk_sp > 0) ? stk_mem[stk_sp-1] : 1'b0;
    assign stk_full  = force_full  || (stk_sp == DEPTH);
    assign stk_empty = force_empty || (stk_sp == 0);

    logic            push_log[$];
    logic [DATA_W-1:0] out_q[$];
    int              hs_count;
    int              acc_count;
    int              both_count;

    always @(posedge clk) begin
        if (stk_push) push_log.push_back(stk_din);
        if (stk_push && stk_pop) both_count++;
        if (m_valid && m_ready) begin
            hs_count++;
            out_q.push_back(m_data);
        end
        if (s_valid && s_ready) acc_count++;
    end

    int checks;
    int failures;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full transaction; full_at/full_len force stk_full for those cycles
    // (cycle 1 = first cycle after the accept edge).
    task automatic run_word(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp,
                            input int out_dly, input int full_at, input int full_len,
                            input int exp_lat);
        int c;
        int hs0;
        logic [DATA_W-1:0] held;
        logic [DATA_W-1:0] din_word;
        logic stable;
        push_log.delete();
        hs0 = hs_count;
        @(negedge clk);
        chk("s_ready_idle", {31'd0, s_ready}, 32'd1);
        s_valid = 1'b1;
        s_data  = d;
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        c = 1;
        while (c < 200) begin
            force_full = (c >= full_at) && (c < full_at + full_len);
            @(negedge clk);
            if (c == full_at && full_len > 0) begin
                chk("stall_cnt_pos", push_log.size(), full_at - 1);
            end
            if (force_full) chk("push_in_stall", {31'd0, stk_push}, 32'd0);
            if (m_valid) break;
            @(posedge clk);
            #1;
            c++;
        end
        force_full = 1'b0;
        chk("latency", c, exp_lat);
        chk("m_data", {24'd0, m_data}, {24'd0, exp});
        din_word = '0;
        for (int i = 0; i < push_log.size() && i < DATA_W; i++) din_word[i] = push_log[i];
        chk("push_count", push_log.size(), DATA_W);
        chk("din_seq", {24'd0, din_word}, {24'd0, d});
        held   = m_data;
        stable = 1'b1;
        for (int i = 0; i < out_dly; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (!m_valid || m_data !== held) stable = 1'b0;
        end
        if (out_dly > 0) begin
            chk("out_hold", {31'd0, stable}, 32'd1);
            chk("no_early_xfer", hs_count, hs0);
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        @(negedge clk);
        chk("s_ready_after", {31'd0, s_ready}, 32'd1);
        chk("m_valid_after", {31'd0, m_valid}, 32'd0);
        chk("one_xfer", hs_count, hs0 + 1);
    endtask

    typedef struct {
        logic [DATA_W-1:0] din;
        logic [DATA_W-1:0] exp;
        int                out_dly;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int hs0;
        int n;
        checks      = 0;
        failures    = 0;
        hs_count    = 0;
        acc_count   = 0;
        both_count  = 0;
        rst_n       = 1'b0;
        s_valid     = 1'b0;
        s_data      = '0;
        m_ready     = 1'b0;
        force_full  = 1'b0;
        force_empty = 1'b0;
        stk_clr     = 1'b0;

        vecs[0] = '{8'hB1, 8'h8D, 0};
        vecs[1] = '{8'h01, 8'h80, 5};
        vecs[2] = '{8'hFF, 8'hFF, 0};
        vecs[3] = '{8'h00, 8'h00, 0};
        vecs[4] = '{8'h3C, 8'h3C, 0};
        vecs[5] = '{8'hA5, 8'hA5, 2};
        vecs[6] = '{8'hC0, 8'h03, 0};
        vecs[7] = '{8'h12, 8'h48, 1};

        repeat (3) @(negedge clk);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data", {24'd0, m_data}, 32'd0);
        chk("rst_push", {31'd0, stk_push}, 32'd0);
        chk("rst_pop", {31'd0, stk_pop}, 32'd0);
        chk("rst_din", {31'd0, stk_din}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_word(vecs[i].din, vecs[i].exp, vecs[i].out_dly, 0, 0, 17 + vecs[i].out_dly * 0);
        end

        // stk_full for 3 cycles while cnt=4
        run_word(8'hB1, 8'h8D, 0, 5, 3, 20);

        // Back-to-back words with s_valid held high
        out_q.delete();
        hs0 = hs_count;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 8'hFF;
        m_ready = 1'b1;
        n = acc_count;
        for (int i = 0; i < 10 && acc_count == n; i++) @(negedge clk);
        chk("b2b_first_acc", acc_count, n + 1);
        s_data = 8'h00;
        chk("b2b_busy", {31'd0, s_ready}, 32'd0);
        for (int i = 0; i < 40 && acc_count == n + 1; i++) @(negedge clk);
        chk("b2b_second_acc", acc_count, n + 2);
        chk("b2b_order", out_q.size(), 1);
        s_valid = 1'b0;
        for (int i = 0; i < 40 && out_q.size() < 2; i++) @(negedge clk);
        chk("b2b_count", hs_count, hs0 + 2);
        if (out_q.size() >= 2) begin
            chk("b2b_word0", {24'd0, out_q[0]}, 32'h0000_00FF);
            chk("b2b_word1", {24'd0, out_q[1]}, 32'h0000_0000);
        end else begin
            chk("b2b_outputs", out_q.size(), 2);
        end
        m_ready = 1'b0;

        // Reset in the 5th PUSH cycle
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 8'hB1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("push_before_rst", {31'd0, stk_push}, 32'd1);
        hs0   = hs_count;
        rst_n = 1'b0;
        #1;
        chk("rst_async_push", {31'd0, stk_push}, 32'd0);
        chk("rst_async_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_async_mvalid", {31'd0, m_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_word(8'h3C, 8'h3C, 0, 0, 0, 17);
        chk("rst_no_extra_xfer", hs_count, hs0 + 1);

`ifdef LIFO_CTRL_WDOG_EN
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 8'h5A;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        force_empty = 1'b1;
        repeat (14) @(posedge clk);
        @(negedge clk);
        chk("wdog_err_early", {31'd0, err}, 32'd0);
        chk("wdog_busy", {31'd0, s_ready}, 32'd0);
        @(negedge clk);
        chk("wdog_err", {31'd0, err}, 32'd1);
        chk("wdog_idle", {31'd0, s_ready}, 32'd1);
        chk("wdog_no_mvalid", {31'd0, m_valid}, 32'd0);
        force_empty = 1'b0;
        stk_clr     = 1'b1;
        @(posedge clk);
        #1;
        stk_clr = 1'b0;
        chk("wdog_err_sticky", {31'd0, err}, 32'd1);
        run_word(8'h3C, 8'h3C, 0, 0, 0, 17);
        chk("wdog_err_clear", {31'd0, err}, 32'd0);
`endif

        chk("push_pop_exclusive", both_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
